sha1_wb_host: RTL and testbench
===============================

# sha1_wb_host

Wishbone initiator that drives one SHA1 register-file peripheral end to end: checks the peripheral ID, clears it, streams one 512-bit block as sixteen message writes, polls the operations register until DONE, then reads the five digest words. It sits between an on-chip requester (a test sequencer or management-side logic) and the Wishbone bus. The requester sees a simple start/busy/done/error interface.

## Interface
- BASE_ADDRESS, 32'h30000024, base of the peripheral register window
- POLL_LIMIT, 1024, maximum OPS status reads before a poll timeout (width 11 bits)
- ACK_LIMIT, 16, cycles to wait for wbm_ack_i per transaction (timeout build only)

Reset is `reset`: synchronous, active-high. Clock is `wb_clk_i`.

- wb_clk_i  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- msg_i  in  512  block; word k = msg_i[32k+31:32k], k = 0..15
- busy  out  1  high from the cycle after accepted start until done/error
- done  out  1  one-cycle pulse; digest_o valid
- error  out  1  one-cycle pulse; err_code valid
- err_code  out  3  1 BAD_ID, 2 MSG_REJECT, 3 PANIC, 4 POLL_TIMEOUT, 5 DIGEST_BUSY, 6 ACK_TIMEOUT; held until next start
- digest_o  out  160  word j at [32j+31:32j], j = 0..4; held until next start
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  bus controls
- wbm_sel_o  out  4  always 4'hF while cyc is high, else 0
- wbm_adr_o, wbm_dat_o  out  32 each  address and write data
- wbm_dat_i  in  32  read data, sampled on ack
- wbm_ack_i  in  1  transaction acknowledge

## Operation
- Register offsets are relative to BASE_ADDRESS: 0x4 ID (expect 32'h53484131), 0x8 OPS, 0xC MSG_IN, 0x10 DIGEST.
- States run in this order: IDLE → ID → CLR_ON → CLR_OFF → MSG → POLL → DIG → IDLE.
  - ID: read 0x4. On a mismatch, raise error with code 1.
  - CLR_ON: write 32'h1 to OPS. This resets the peripheral message index and DONE.
  - CLR_OFF: write 32'h0 to OPS. This re-enables message loading.
  - MSG: 16 writes to 0xC, word 0 first. Every write response must equal 32'h1. Any other value raises code 2 immediately, and the remaining words are not sent.
  - POLL: read OPS.
    - bit2 set (PANIC): code 3.
    - bit3 set (DONE): go to DIG.
    - Otherwise, re-read after one idle cycle.
    - After POLL_LIMIT reads without DONE: code 4.
  - DIG: 5 reads of 0x10. Read j loads digest_o word j. A response of 32'hfffffff0 raises code 5.
- A start request while busy is ignored.
- An ack arriving with no outstanding transaction is ignored.
- msg_i is captured into an internal register on start. Later changes to msg_i do not affect the run in progress.

## Timing
- Reset values:
  - All outputs are 0, including cyc, stb, we, sel, adr, dat, done, error, err_code and digest_o.
  - The state machine is in IDLE.
- Reset mid-transaction: cyc and stb are 0 from the reset edge, with no completion pulse. A pending ack is discarded.
- Transaction request in cycle N:
  - cyc=stb=1 with adr, we and dat valid in cycle N.
  - stb is high for exactly one cycle; cyc stays high until ack.
  - adr, we and dat are held until ack.
- Ack in cycle M: wbm_dat_i is sampled at M, cyc drops at M+1, and M+1 is a mandatory idle cycle. The next request is issued no earlier than M+2.
- With a one-cycle-latency responder, each transaction takes 3 cycles.
- start at cycle 0: busy=1 and the ID request at cycle 1.
- With P polls, done/error pulses 3·(24+P) cycles after the first request. busy drops in the same cycle as the pulse.
- done and error are mutually exclusive and last exactly one cycle each.

## Configuration
- SHA1_WB_HOST_ACK_TIMEOUT_EN:
  - Defined: a per-transaction counter runs. If ACK_LIMIT cycles pass after the request without wbm_ack_i, cyc drops and error pulses with code 6.
  - Undefined: the block waits for ack indefinitely and code 6 never occurs.

## Test plan
- Responder model with correct ID, 1-cycle ack, DONE on the 3rd poll, digest words 32'h67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0:
  - done pulses at cycle 3·27 after the first request.
  - digest_o = {C3D2E1F0, 10325476, 98BADCFE, EFCDAB89, 67452301}.
  - Exactly 16 MSG_IN writes are seen, in word order 0..15.
- ID read returns 32'hf00df00d → error with code 1 after 1 transaction; no writes issued.
- 5th MSG_IN write answered 32'h0fffffea → error with code 2; total writes = 2 OPS + 5 MSG.
- POLL reads keep returning 0 with POLL_LIMIT=4 → exactly 4 OPS reads, then code 4. In a second run, an OPS read returning 32'h4 gives code 3.
- reset asserted during MSG word 7 while cyc is high → cyc=stb=0 at the next edge, all outputs 0, and a following start runs cleanly to done.
- Timeout build, responder silent on the ID read → cyc is high for ACK_LIMIT cycles, then error with code 6. Non-timeout build: cyc stays high and busy stays high.

Source files
------------

// File: rtl/sha1_wb_host_if.sv
// sha1_wb_host_if: Wishbone initiator bus bundle between sha1_wb_host and its peripheral
interface sha1_wb_host_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  modport master(output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
                 input wbm_dat_i, wbm_ack_i);
  modport slave(input wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
                output wbm_dat_i, wbm_ack_i);
endinterface

// File: rtl/sha1_wb_host.sv
// sha1_wb_host: Wishbone initiator running one SHA1 block through the register-file peripheral (optional SHA1_WB_HOST_ACK_TIMEOUT_EN)
module sha1_wb_host #(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
  parameter int          POLL_LIMIT   = 1024,
  parameter int          ACK_LIMIT    = 16
) (
  input  logic          wb_clk_i,
  input  logic          reset,
  input  logic          start,
  input  logic [511:0]  msg_i,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [2:0]    err_code,
  output logic [159:0]  digest_o,
  sha1_wb_host_if.master wb
);
  localparam logic [2:0] S_IDLE = 3'd0, S_ID = 3'd1, S_CLR_ON = 3'd2, S_CLR_OFF = 3'd3,
                         S_MSG = 3'd4, S_POLL = 3'd5, S_DIG = 3'd6;
  localparam logic [31:0] A_ID = BASE_ADDRESS + 32'h4, A_OPS = BASE_ADDRESS + 32'h8,
                          A_MSG = BASE_ADDRESS + 32'hC, A_DIG = BASE_ADDRESS + 32'h10;
  localparam logic [31:0] ID_VAL = 32'h53484131;
  logic [2:0]   r_state, w_nstate;
  logic         r_cyc, r_stb, r_we, r_gap, r_busy, r_done, r_error;
  logic [31:0]  r_adr, r_wdat, r_rdat;
  logic [10:0]  r_cnt, w_ncnt;
  logic [511:0] r_msg;
  logic [2:0]   r_err_code, w_code;
  logic [159:0] r_digest;
  logic         w_go, w_fin, w_err, w_we;
  logic [31:0]  w_adr, w_wdat;
  logic [3:0]   w_widx;
`ifdef SHA1_WB_HOST_ACK_TIMEOUT_EN
  logic [7:0]   r_acnt;
`endif
  assign wb.wbm_cyc_o = r_cyc;
  assign wb.wbm_stb_o = r_stb;
  assign wb.wbm_we_o  = r_we;
  assign wb.wbm_sel_o = r_cyc ? 4'hF : 4'h0;
  assign wb.wbm_adr_o = r_adr;
  assign wb.wbm_dat_o = r_wdat;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_code = r_err_code;
  assign digest_o = r_digest;
  // Sequencing decision: made in the idle cycle after each ack (r_gap), or on start in IDLE
  always_comb begin
    w_go = 1'b0;
    w_fin = 1'b0;
    w_err = 1'b0;
    w_code = 3'd0;
    w_nstate = r_state;
    w_we = 1'b0;
    w_adr = A_OPS;
    w_widx = 4'd0;
    w_ncnt = 11'd0;
    case (r_state)
      S_IDLE: begin
        w_go = start;
        w_nstate = S_ID;
        w_adr = A_ID;
      end
      S_ID: if (r_gap) begin
        w_go = r_rdat == ID_VAL;
        w_err = !w_go;
        w_code = 3'd1;
        w_nstate = S_CLR_ON;
        w_we = 1'b1;
      end
      S_CLR_ON: if (r_gap) begin
        w_go = 1'b1;
        w_nstate = S_CLR_OFF;
        w_we = 1'b1;
      end
      S_CLR_OFF: if (r_gap) begin
        w_go = 1'b1;
        w_nstate = S_MSG;
        w_we = 1'b1;
        w_adr = A_MSG;
      end
      S_MSG: if (r_gap) begin
        w_err = r_rdat != 32'h1;
        w_code = 3'd2;
        w_go = !w_err;
        w_nstate = r_cnt == 11'd15 ? S_POLL : S_MSG;
        w_we = r_cnt != 11'd15;
        w_adr = r_cnt == 11'd15 ? A_OPS : A_MSG;
        w_widx = r_cnt[3:0] + 4'd1;
        w_ncnt = r_cnt == 11'd15 ? 11'd0 : r_cnt + 11'd1;
      end
      S_POLL: if (r_gap) begin
        w_err = r_rdat[2] || (!r_rdat[3] && r_cnt == 11'(POLL_LIMIT - 1));
        w_code = r_rdat[2] ? 3'd3 : 3'd4;
        w_go = !w_err;
        w_nstate = r_rdat[3] ? S_DIG : S_POLL;
        w_adr = r_rdat[3] ? A_DIG : A_OPS;
        w_ncnt = r_rdat[3] ? 11'd0 : r_cnt + 11'd1;
      end
      S_DIG: if (r_gap) begin
        w_err = r_rdat == 32'hfffffff0;
        w_code = 3'd5;
        w_fin = !w_err && r_cnt == 11'd4;
        w_go = !w_err && !w_fin;
        w_adr = A_DIG;
        w_ncnt = r_cnt + 11'd1;
      end
      default: ;
    endcase
`ifdef SHA1_WB_HOST_ACK_TIMEOUT_EN
    if (r_cyc && !wb.wbm_ack_i && r_acnt == 8'(ACK_LIMIT - 1)) begin
      w_err = 1'b1;
      w_code = 3'd6;
    end
`endif
    w_wdat = r_state == S_ID ? 32'h1 : (w_adr == A_MSG ? r_msg[{w_widx, 5'd0} +: 32] : 32'h0);
  end
  // Bus cycle tracking, request launch, result capture and status pulses
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cyc <= 1'b0;
      r_stb <= 1'b0;
      r_we <= 1'b0;
      r_adr <= 32'h0;
      r_wdat <= 32'h0;
      r_rdat <= 32'h0;
      r_gap <= 1'b0;
      r_cnt <= 11'd0;
      r_msg <= 512'h0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_error <= 1'b0;
      r_err_code <= 3'd0;
      r_digest <= 160'h0;
`ifdef SHA1_WB_HOST_ACK_TIMEOUT_EN
      r_acnt <= 8'd0;
`endif
    end else begin
      r_stb <= w_go;
      r_done <= w_fin;
      r_error <= w_err;
      r_gap <= r_cyc && wb.wbm_ack_i;
      if (r_cyc && wb.wbm_ack_i) r_rdat <= wb.wbm_dat_i;
      if (r_cyc && (wb.wbm_ack_i || w_err)) r_cyc <= 1'b0;
`ifdef SHA1_WB_HOST_ACK_TIMEOUT_EN
      r_acnt <= w_go ? 8'd0 : r_acnt + 8'd1;
`endif
      if (w_go) begin
        r_cyc <= 1'b1;
        r_we <= w_we;
        r_adr <= w_adr;
        r_wdat <= w_wdat;
        r_state <= w_nstate;
        r_cnt <= w_ncnt;
      end
      if (w_fin || w_err) begin
        r_state <= S_IDLE;
        r_busy <= 1'b0;
      end
      if (w_err) r_err_code <= w_code;
      if (r_gap && r_state == S_DIG) r_digest[{r_cnt[2:0], 5'd0} +: 32] <= r_rdat;
      if (r_state == S_IDLE && start) begin
        r_msg <= msg_i;
        r_busy <= 1'b1;
        r_err_code <= 3'd0;
        r_digest <= 160'h0;
      end
    end
  end
endmodule

// File: tb/tb_sha1_wb_host.sv
// tb_sha1_wb_host: scoreboard bench for sha1_wb_host against a scripted SHA1 peripheral responder
module tb_sha1_wb_host;
  localparam logic [31:0] BASE = 32'h30000024;
  localparam logic [31:0] ID_OK = 32'h53484131;
  localparam logic [159:0] DIG = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
  logic wb_clk_i = 1'b0, reset = 1'b1, start = 1'b0;
  logic [511:0] msg_i = 512'h0;
  logic busy, done, error;
  logic [2:0] err_code;
  logic [159:0] digest_o;
  sha1_wb_host_if bus();
  sha1_wb_host #(.BASE_ADDRESS(BASE), .POLL_LIMIT(4), .ACK_LIMIT(16)) dut (
    .wb_clk_i(wb_clk_i), .reset(reset), .start(start), .msg_i(msg_i), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .digest_o(digest_o), .wb(bus));
  always #5 wb_clk_i = ~wb_clk_i;
  typedef struct { bit is_err; logic [2:0] code; logic [159:0] dig; int t; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int total = 0, bad = 0, cyc_n = 0;
  logic [31:0] cfg_id = ID_OK;
  int cfg_rej = 0, cfg_done = 3, cfg_panic = 0, cfg_dbusy = 0;
  bit silent = 1'b0;
  logic [511:0] exp_msg = 512'h0;
  logic [31:0] dig_w [5] = '{32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
  int n_tr = 0, n_wr = 0, n_msg = 0, n_poll = 0, n_dig = 0;
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;
  // scripted peripheral: one-cycle ack, responses chosen by cfg_*
  always @(posedge wb_clk_i) begin
    bus.wbm_ack_i <= 1'b0;
    if (start && !busy) begin
      n_tr <= 0; n_wr <= 0; n_msg <= 0; n_poll <= 0; n_dig <= 0;
    end else if (bus.wbm_cyc_o && bus.wbm_stb_o && !silent) begin
      bus.wbm_ack_i <= 1'b1;
      n_tr <= n_tr + 1;
      if (bus.wbm_we_o) n_wr <= n_wr + 1;
      case (bus.wbm_adr_o)
        BASE + 32'h4: bus.wbm_dat_i <= cfg_id;
        BASE + 32'h8: begin
          if (!bus.wbm_we_o) n_poll <= n_poll + 1;
          bus.wbm_dat_i <= bus.wbm_we_o ? 32'h0 :
                           (n_poll + 1 == cfg_panic) ? 32'h4 : (n_poll + 1 == cfg_done) ? 32'h8 : 32'h0;
        end
        BASE + 32'hC: begin
          n_msg <= n_msg + 1;
          chk("msg_word", {128'h0, bus.wbm_dat_o}, n_msg < 16 ? {128'h0, exp_msg[n_msg*32 +: 32]} : 160'hdead);
          bus.wbm_dat_i <= (n_msg + 1 == cfg_rej) ? 32'h0fffffea : 32'h1;
        end
        BASE + 32'h10: begin
          n_dig <= n_dig + 1;
          bus.wbm_dat_i <= (n_dig + 1 == cfg_dbusy) ? 32'hfffffff0 : (n_dig < 5 ? dig_w[n_dig] : 32'h0);
        end
        default: begin
          total++; bad++;
          $display("FAIL bus_addr: got %0h want a register in the window", bus.wbm_adr_o);
          bus.wbm_dat_i <= 32'h0;
        end
      endcase
    end
  end
  // monitor: pops the expected outcome whenever done or error pulses
  always @(negedge wb_clk_i) begin
    if (!reset) chk("sel", {156'h0, bus.wbm_sel_o}, {156'h0, bus.wbm_cyc_o ? 4'hF : 4'h0});
    if (done || error) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: got done=%0b error=%0b want none", done, error);
      end else begin
        mon_e = q.pop_front();
        chk("pulse_kind", {done, error}, mon_e.is_err ? 2'b01 : 2'b10);
        chk("busy_at_pulse", busy, 0);
        chk("pulse_cycle", cyc_n, mon_e.t);
        if (mon_e.is_err) chk("err_code", err_code, mon_e.code);
        else chk("digest", digest_o, mon_e.dig);
      end
    end
  end
  task automatic wait_q();
    for (int i = 0; i < 600 && q.size() != 0; i++) @(negedge wb_clk_i);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL no_pulse: got none want done/error within 600 cycles");
      q.delete();
    end
  endtask
  task automatic launch(input bit is_err, input logic [2:0] code, input int toff, input logic [7:0] seed);
    logic [511:0] m;
    for (int k = 0; k < 16; k++) m[k*32 +: 32] = {seed, 8'(k), 16'hC0DE};
    @(negedge wb_clk_i);
    msg_i = m; exp_msg = m; start = 1'b1;
    if (toff > 0) q.push_back('{is_err, code, DIG, cyc_n + toff});
    @(negedge wb_clk_i);
    start = 1'b0;
  endtask
  task automatic run(input logic [31:0] id, input int rej, input int dn, input int pn, input int db,
                     input bit is_err, input logic [2:0] code, input int toff, input bit poke);
    cfg_id = id; cfg_rej = rej; cfg_done = dn; cfg_panic = pn; cfg_dbusy = db;
    launch(is_err, code, toff, 8'(toff));
    if (poke) begin
      repeat (8) @(negedge wb_clk_i);
      start = 1'b1; msg_i = ~msg_i;
      @(negedge wb_clk_i);
      start = 1'b0;
    end
    wait_q();
  endtask
  initial begin
    repeat (3) @(negedge wb_clk_i);
    chk("rst_cyc", bus.wbm_cyc_o, 0);
    chk("rst_stb", bus.wbm_stb_o, 0);
    chk("rst_we", bus.wbm_we_o, 0);
    chk("rst_sel", bus.wbm_sel_o, 0);
    chk("rst_adr", bus.wbm_adr_o, 0);
    chk("rst_dat", bus.wbm_dat_o, 0);
    chk("rst_flags", {busy, done, error, err_code}, 0);
    chk("rst_digest", digest_o, 0);
    reset = 1'b0;
    run(ID_OK, 0, 3, 0, 0, 1'b0, 3'd0, 82, 1'b1);
    chk("full_msg_writes", n_msg, 16);
    chk("full_writes", n_wr, 18);
    chk("full_polls", n_poll, 3);
    run(32'hf00df00d, 0, 3, 0, 0, 1'b1, 3'd1, 4, 1'b0);
    chk("badid_trans", n_tr, 1);
    chk("badid_writes", n_wr, 0);
    run(ID_OK, 5, 3, 0, 0, 1'b1, 3'd2, 25, 1'b0);
    chk("reject_msg_writes", n_msg, 5);
    chk("reject_writes", n_wr, 7);
    run(ID_OK, 0, 0, 0, 0, 1'b1, 3'd4, 70, 1'b0);
    chk("timeout_polls", n_poll, 4);
    run(ID_OK, 0, 0, 2, 0, 1'b1, 3'd3, 64, 1'b0);
    chk("panic_polls", n_poll, 2);
    run(ID_OK, 0, 3, 0, 3, 1'b1, 3'd5, 76, 1'b0);
    chk("digbusy_reads", n_dig, 3);
    cfg_id = ID_OK; cfg_rej = 0; cfg_done = 3; cfg_panic = 0; cfg_dbusy = 0;
    launch(1'b0, 3'd0, 0, 8'h77);
    repeat (30) @(negedge wb_clk_i);
    chk("pre_rst_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b11);
    chk("pre_rst_msg_count", n_msg, 7);
    reset = 1'b1;
    @(negedge wb_clk_i);
    chk("midrst_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o}, 0);
    chk("midrst_flags", {busy, done, error, err_code}, 0);
    chk("midrst_digest", digest_o, 0);
    @(negedge wb_clk_i);
    reset = 1'b0;
    run(ID_OK, 0, 3, 0, 0, 1'b0, 3'd0, 82, 1'b0);
    chk("post_rst_msg_writes", n_msg, 16);
    silent = 1'b1;
`ifdef SHA1_WB_HOST_ACK_TIMEOUT_EN
    launch(1'b1, 3'd6, 17, 8'h55);
    wait_q();
`else
    launch(1'b1, 3'd6, 0, 8'h55);
    repeat (40) @(negedge wb_clk_i);
    chk("hang_cyc", bus.wbm_cyc_o, 1);
    chk("hang_busy", busy, 1);
`endif
    reset = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    reset = 1'b0;
    silent = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
